// File: rtl/dec24_pulse.sv
// dec24_pulse: registered 2-to-4 decoder with a valid/ready input handshake.
// An accepted code drives its one-hot output line for in_hold+1 cycles, then
// the block either returns to idle or, if another pair is offered on the last
// drive cycle, reloads immediately with no idle gap between strobes.
//
// Handshake: a code/hold pair is transferred on a rising edge where both
// in_valid and in_ready are high. in_ready depends only on registered state
// (and rst_n), never on in_valid, so no combinational loop can form through a
// producer that waits on in_ready. in_code/in_hold are ignored when no transfer
// happens.
module dec24_pulse #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_code,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [3:0]        out,
  output logic              busy,
  output logic              done,
  output logic              state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] cnt;
  logic              last_cycle;
  logic              accept;

  // Last drive cycle: the counter has run out while a line is being driven.
  assign last_cycle = (state == DRIVE) && (cnt == '0);

  // Ready when idle or on the final drive cycle; held low throughout reset.
  assign in_ready = rst_n && ((state == IDLE) || (cnt == '0));
  assign accept   = in_valid && in_ready;

  // Status outputs derived from registered state only, so they are glitch-free.
  assign done      = last_cycle;
  assign busy      = (state == DRIVE);
  assign state_dbg = (state == DRIVE);

  // Decoder FSM: load on accept, count down the hold, drop the line when done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= DRIVE;
            out   <= 4'b0001 << in_code;
            cnt   <= in_hold;
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            // Still holding the line; the counter never wraps below zero.
            cnt <= cnt - 1'b1;
          end else if (accept) begin
            // Back-to-back reload: the line may move directly to a new bit.
            state <= DRIVE;
            out   <= 4'b0001 << in_code;
            cnt   <= in_hold;
          end else begin
            state <= IDLE;
            out   <= 4'b0000;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          out   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: doc/dec24_pulse.md
# dec24_pulse

Registered 2-to-4 decoder with a valid/ready input handshake and a programmable hold time, the inverse of the team's 4-to-2 priority encoders. It accepts a 2-bit code and drives the matching one-hot output line for a requested number of cycles. It then signals completion and can accept the next code with no idle gap. It sits on the request side of an encoder/decoder pair and regenerates one-hot strobes from compressed indices.

## Interface
- HOLD_W, 4, width of the hold-count field; maximum drive length is 2^HOLD_W cycles
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  code/hold pair presented
- in_ready  output  1  block can accept a pair this cycle (combinational from state)
- in_code  input  2  index to decode
- in_hold  input  HOLD_W  extra drive cycles beyond the first
- out  output  4  one-hot decoded strobe, registered
- busy  output  1  high while out is being driven
- done  output  1  one-cycle pulse on the final drive cycle

## Operation
- States:
  - IDLE: out=0, busy=0.
  - DRIVE: out one-hot, busy=1, down-counter cnt[HOLD_W-1:0] active.
- Accept condition: in_valid && in_ready.
  - in_ready = 1 in IDLE.
  - in_ready = 1 in DRIVE when cnt==0 (last drive cycle).
  - in_ready = 0 otherwise.
  - in_ready is forced 0 while rst_n is low.
- On accept, on the next edge:
  - state <= DRIVE.
  - out <= 4'b0001 << in_code, so code 0->0001, 1->0010, 2->0100, 3->1000.
  - cnt <= in_hold.
- In DRIVE with cnt!=0: cnt decrements by 1 each cycle; out holds.
- In DRIVE with cnt==0: done=1 this cycle.
  - If accept: reload per the accept rule, staying in DRIVE. This is back-to-back with no gap; out may change line directly.
  - If no accept: next state IDLE, out<=0.
- done = (state==DRIVE) && (cnt==0). It is combinational from registered state, so it is glitch-free.
- Total drive length per transaction = in_hold+1 cycles.
  - in_hold=0 gives a single-cycle strobe.
  - in_hold=2^HOLD_W-1 gives 2^HOLD_W cycles.
- in_code and in_hold are sampled only on accept. Changes while in_ready=0 are ignored.
- out is always zero or exactly one-hot; it never has more than one bit set.
- The counter does not wrap: decrement occurs only when cnt!=0.

## Timing
- Reset (asynchronous assert, synchronous to clk on release):
  - state=IDLE, cnt=0, out=4'b0000, busy=0, done=0, in_ready=0 while asserted.
  - in_ready=1 in the first cycle after deassertion.
- Latency: accept at edge N gives out valid from edge N+1, for in_hold+1 cycles.
- Throughput: one transaction per in_hold+1 cycles with continuous in_valid.
- Reset mid-DRIVE: out, busy and done clear immediately (asynchronously). The in-flight transaction is dropped and not resumed.
- in_valid asserted during reset is ignored; no accept occurs.
- busy equals |out in every cycle.

## Test plan
- Reset then idle: rst_n low 3 cycles, release -> out=0000, busy=0, done=0, in_ready=1; in_ready=0 during reset.
- Single strobe per code: code=0..3, hold=0, one pair each with gaps -> out=0001/0010/0100/1000 for exactly 1 cycle each, done coincident, in_ready=1 throughout.
- Long hold: code=2, hold=5 -> out=0100 for 6 cycles, in_ready=0 for the first 5 cycles, done only on the 6th, then out=0000.
- Back-to-back: in_valid held high with code=1/hold=1 then code=3/hold=0 -> out=0010,0010,1000 then 0000, no zero gap between lines, done high on the 2nd and 3rd cycles.
- Input change while busy: accept code=0/hold=3, then switch in_code to 3 while in_ready=0 -> out stays 0001 for 4 cycles; the new code is accepted only on the last drive cycle.
- Reset mid-operation and maximum hold: HOLD_W=4, code=3, hold=15, assert rst_n low at drive cycle 7 -> out=0000 immediately, no done pulse; repeat without reset -> out=1000 for exactly 16 cycles.
